// File: rtl/sobol_sched_pkg.sv
// sobol_sched_pkg: shared widths, FSM states and per-sample tag for the Sobol sample scheduler.
package sobol_sched_pkg;
  localparam int ICDF_W   = 13;
  localparam int TAG_ID_W = 3;
  typedef enum logic [1:0] {IDLE, ARB, RUN, DRAIN} state_e;
  typedef struct packed {
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } tag_t;
endpackage

// File: rtl/sobol_sched_fifo.sv
// sobol_sched_fifo: synchronous data+tag FIFO with occupancy count and a registered head.
module sobol_sched_fifo
  import sobol_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [ICDF_W-1:0]          data_i,
  input  tag_t                       tag_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       valid_o,
  output logic [ICDF_W-1:0]          data_o,
  output tag_t                       tag_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  typedef struct packed {
    logic [ICDF_W-1:0] data;
    tag_t              tag;
  } ent_t;
  ent_t             mem_q [DEPTH];
  ent_t             head_q, head_d, wr_ent;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, pop;
  // The head register is loaded with the post-update head; a push into an empty queue bypasses memory.
  always_comb begin
    pop    = pop_i & valid_q;
    wr_ent = '{data: data_i, tag: tag_i};
    wr_d   = wr_q + PTR_W'(push_i);
    rd_d   = rd_q + PTR_W'(pop);
    cnt_d  = cnt_q + CNT_W'(push_i) - CNT_W'(pop);
    head_d = (cnt_d == '0) ? '0 : (push_i && wr_q == rd_d) ? wr_ent : mem_q[rd_d];
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wr_ent;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= cnt_d != '0;
      head_q  <= head_d;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && !pop && cnt_q == CNT_W'(DEPTH)));
  assign count_o = cnt_q;
  assign valid_o = valid_q;
  assign data_o  = head_q.data;
  assign tag_o   = head_q.tag;
endmodule

// File: rtl/sobol_sample_scheduler.sv
// sobol_sample_scheduler: round-robin burst arbiter sharing one Sobol/ICDF core, with credit flow control.
// Define SOBOL_SCHED_PERF_EN to add the stall_cnt/sample_cnt performance counters.
module sobol_sample_scheduler
  import sobol_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LEN_W      = 8,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       core_start,
  input  logic [ICDF_W-1:0]          core_icdf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ICDF_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_last
`ifdef SOBOL_SCHED_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                sample_cnt
`endif
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int REM_W = LEN_W + 1;
  state_e              state_q;
  logic [ID_W-1:0]     rr_q, id_q, pick;
  logic [REM_W-1:0]    rem_q, pick_rem;
  logic [LEN_W-1:0]    pick_len;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [PIPE_LAT-1:0] dl_vld_q;
  tag_t                dl_tag_q [PIPE_LAT];
  tag_t                cur_tag, tap_tag, head_tag;
  logic [CNT_W-1:0]    in_flight_q, fifo_count, credit;
  logic                found, tap_vld, pop, unused_tag_id;
  int                  k;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      k = (int'(rr_q) + i) % NUM_REQ;
      if (req[k]) begin
        found = 1'b1;
        pick  = ID_W'(k);
      end
    end
    pick_len   = req_len[int'(pick)*LEN_W +: LEN_W];
    pick_rem   = (pick_len == '0) ? REM_W'(1) << LEN_W : {1'b0, pick_len};
    credit     = CNT_W'(FIFO_DEPTH) - fifo_count - in_flight_q;
    core_start = (state_q == RUN) && (credit != '0);
    cur_tag    = '{id: TAG_ID_W'(id_q), last: rem_q == REM_W'(1)};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      rem_q   <= '0;
      gnt_q   <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: if (found) begin
          gnt_q   <= NUM_REQ'(1) << pick;
          id_q    <= pick;
          rem_q   <= pick_rem;
          rr_q    <= (pick == ID_W'(NUM_REQ-1)) ? '0 : pick + ID_W'(1);
          state_q <= ARB;
        end
        ARB: state_q <= RUN;
        RUN: if (core_start) begin
          rem_q <= rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_q <= DRAIN;
        end
        DRAIN: if (in_flight_q == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // Tags travel alongside the core pipeline so each result is matched to its start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld_q    <= '0;
      in_flight_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dl_tag_q[i] <= '0;
    end else begin
      dl_vld_q[0] <= core_start;
      dl_tag_q[0] <= cur_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_tag_q[i] <= dl_tag_q[i-1];
      end
      in_flight_q <= in_flight_q + CNT_W'(core_start) - CNT_W'(tap_vld);
    end
  end
  assign tap_vld = dl_vld_q[PIPE_LAT-1];
  assign tap_tag = dl_tag_q[PIPE_LAT-1];
  assign pop     = out_valid & out_ready;
  sobol_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tap_vld),
    .data_i  (core_icdf),
    .tag_i   (tap_tag),
    .pop_i   (pop),
    .count_o (fifo_count),
    .valid_o (out_valid),
    .data_o  (out_data),
    .tag_o   (head_tag)
  );
  assign gnt           = gnt_q;
  assign out_id        = head_tag.id[ID_W-1:0];
  assign out_last      = head_tag.last;
  assign unused_tag_id = ^head_tag.id;
  assign busy          = (state_q != IDLE) | (in_flight_q != '0) | (fifo_count != '0);
`ifdef SOBOL_SCHED_PERF_EN
  logic [31:0] stall_q, sample_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      sample_q <= '0;
    end else begin
      if (state_q == RUN && credit == '0) stall_q <= stall_q + 32'd1;
      if (pop) sample_q <= sample_q + 32'd1;
    end
  end
  assign stall_cnt  = stall_q;
  assign sample_cnt = sample_q;
`endif
endmodule
